// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register write scoreboard.
// Register 0 is hard-wired and never tracked; register 31 is the link register.
package reg_scoreboard_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int LINK_REG  = 31;
  localparam int CNT_W     = 2;
  localparam int TOTAL_W   = 7;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;

  function automatic logic is_tracked(input reg_addr_t r);
    return r != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard_pend_counter.sv
// Saturating up/down pending-write counter for one register.
// Simultaneous inc and dec cancel; underflow flags a dec at zero with no inc.
module pend_counter
  import reg_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      dec,
  input  logic      clr,
  output pend_cnt_t cnt,
  output logic      underflow
);

  localparam pend_cnt_t CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + pend_cnt_t'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - pend_cnt_t'(1);
    end
  end

  assign underflow = dec && !inc && (cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write scoreboard: hazard detection at issue,
// issue throttling per destination, running pending total and write-back error pulse.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_PEND = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [ADDR_W-1:0]  issue_dest,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_dest,
  input  logic [ADDR_W-1:0]  src_a,
  input  logic [ADDR_W-1:0]  src_b,
  output logic               hazard_a,
  output logic               hazard_b,
  input  logic               flush,
  output logic [TOTAL_W-1:0] pend_total,
  output logic               wb_err
);

  localparam pend_cnt_t MAX_CNT = pend_cnt_t'(MAX_PEND);

  pend_cnt_t              cnt [REG_COUNT];
  logic [REG_COUNT-1:1]   inc;
  logic [REG_COUNT-1:1]   dec;
  logic [REG_COUNT-1:1]   underflow;
  logic                   issue_acc;
  logic                   inc_eff;
  logic                   dec_eff;
  logic                   wb_underflow;

  assign cnt[0] = '0;

  // Handshake: an issue transfers on any cycle where issue_valid && issue_ready;
  // issue_ready is a pure function of the current count, never of issue_valid.
  assign issue_ready = !is_tracked(issue_dest) || (cnt[issue_dest] < MAX_CNT);
  assign issue_acc   = issue_valid && issue_ready;

  assign hazard_a = is_tracked(src_a) && (cnt[src_a] != '0);
  assign hazard_b = is_tracked(src_b) && (cnt[src_b] != '0);

  always_comb begin
    inc = '0;
    dec = '0;
    if (issue_acc && is_tracked(issue_dest)) inc[issue_dest] = 1'b1;
    if (wb_valid && is_tracked(wb_dest))     dec[wb_dest]    = 1'b1;
  end

  for (genvar i = 1; i <= LINK_REG; i++) begin : g_cnt
    pend_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[i]),
      .dec       (dec[i]),
      .clr       (flush),
      .cnt       (cnt[i]),
      .underflow (underflow[i])
    );
  end

  // A same-register issue+wb at zero cancels in the counter, so it is not an underflow
  // and still counts as one decrement against the issue's increment.
  assign wb_underflow = |underflow;
  assign inc_eff      = issue_acc && is_tracked(issue_dest);
  assign dec_eff      = wb_valid && is_tracked(wb_dest) && !wb_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_total <= '0;
      wb_err     <= 1'b0;
    end else if (flush) begin
      pend_total <= '0;
      wb_err     <= 1'b0;
    end else begin
      wb_err <= wb_underflow;
      if (inc_eff && !dec_eff)      pend_total <= pend_total + TOTAL_W'(1);
      else if (dec_eff && !inc_eff) pend_total <= pend_total - TOTAL_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector bench for reg_scoreboard: table of per-cycle stimulus and
// expected outputs, plus a hand-written asynchronous reset sequence.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int NV = 33;

  typedef struct {
    logic       iv;
    logic [4:0] id;
    logic       wv;
    logic [4:0] wd;
    logic [4:0] sa;
    logic [4:0] sb;
    logic       fl;
    logic       r;
    logic       ha;
    logic       hb;
    logic [6:0] tot;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_dest;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_dest;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       hazard_a;
  logic       hazard_b;
  logic       flush;
  logic [6:0] pend_total;
  logic       wb_err;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t        vecs [NV];
  logic [10:0] exp_q[$];

  reg_scoreboard #(.MAX_PEND(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .src_a       (src_a),
    .src_b       (src_b),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .flush       (flush),
    .pend_total  (pend_total),
    .wb_err      (wb_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input int id, input logic wv, input int wd,
                              input int sa, input int sb, input logic fl,
                              input logic r, input logic ha, input logic hb,
                              input int tot, input logic err);
    vec_t v;
    v.iv = iv; v.id = 5'(id); v.wv = wv; v.wd = 5'(wd);
    v.sa = 5'(sa); v.sb = 5'(sb); v.fl = fl;
    v.r = r; v.ha = ha; v.hb = hb; v.tot = 7'(tot); v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] id, input logic wv, input logic [4:0] wd,
                       input logic [4:0] sa, input logic [4:0] sb, input logic fl);
    issue_valid = iv; issue_dest = id; wb_valid = wv; wb_dest = wd;
    src_a = sa; src_b = sb; flush = fl;
  endtask

  initial begin
    // inputs:  iv  id  wv  wd  sa  sb  fl | ready ha hb total err
    vecs[0]  = mk(0,  0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0);
    vecs[1]  = mk(1,  5, 0,  0,  5,  0, 0,  1, 0, 0, 0, 0);
    vecs[2]  = mk(0,  5, 0,  0,  5,  0, 0,  1, 1, 0, 1, 0);
    vecs[3]  = mk(0,  0, 1,  5,  5,  0, 0,  1, 1, 0, 1, 0);
    vecs[4]  = mk(0,  0, 0,  0,  5,  0, 0,  1, 0, 0, 0, 0);
    vecs[5]  = mk(1,  0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0);
    vecs[6]  = mk(0,  0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 31, 0,  0,  0, 31, 0,  1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 31, 0,  0,  0, 31, 0,  1, 0, 1, 1, 0);
    vecs[9]  = mk(1, 31, 0,  0,  0, 31, 0,  1, 0, 1, 2, 0);
    vecs[10] = mk(1, 31, 0,  0,  0, 31, 0,  0, 0, 1, 3, 0);
    vecs[11] = mk(0, 31, 0,  0,  0, 31, 0,  0, 0, 1, 3, 0);
    vecs[12] = mk(0,  0, 1,  7,  7,  0, 0,  1, 0, 0, 3, 0);
    vecs[13] = mk(0,  0, 0,  0,  7,  0, 0,  1, 0, 0, 3, 1);
    vecs[14] = mk(0,  0, 0,  0,  0,  0, 0,  1, 0, 0, 3, 0);
    vecs[15] = mk(1,  9, 0,  0,  0,  0, 0,  1, 0, 0, 3, 0);
    vecs[16] = mk(1,  9, 1,  9,  9,  0, 0,  1, 1, 0, 4, 0);
    vecs[17] = mk(0,  9, 0,  0,  9,  0, 0,  1, 1, 0, 4, 0);
    vecs[18] = mk(1,  9, 0,  0,  0,  0, 0,  1, 0, 0, 4, 0);
    vecs[19] = mk(1,  9, 0,  0,  0,  0, 0,  1, 0, 0, 5, 0);
    vecs[20] = mk(1,  9, 1,  9,  9,  0, 0,  0, 1, 0, 6, 0);
    vecs[21] = mk(0,  9, 0,  0,  9,  0, 0,  1, 1, 0, 5, 0);
    vecs[22] = mk(1, 12, 1, 12, 12,  0, 0,  1, 0, 0, 5, 0);
    vecs[23] = mk(0,  0, 0,  0, 12,  0, 0,  1, 0, 0, 5, 0);
    vecs[24] = mk(1,  3, 1, 31,  3, 31, 0,  1, 0, 1, 5, 0);
    vecs[25] = mk(0, 31, 0,  0,  3, 31, 0,  1, 1, 1, 5, 0);
    vecs[26] = mk(0,  0, 1,  0,  0,  0, 0,  1, 0, 0, 5, 0);
    vecs[27] = mk(0,  0, 0,  0,  0,  0, 0,  1, 0, 0, 5, 0);
    vecs[28] = mk(1,  4, 1,  9,  9,  3, 1,  1, 1, 1, 5, 0);
    vecs[29] = mk(0, 31, 0,  0,  9,  3, 0,  1, 0, 0, 0, 0);
    vecs[30] = mk(0,  0, 1,  7,  0,  0, 0,  1, 0, 0, 0, 0);
    vecs[31] = mk(0,  0, 0,  0,  0,  0, 1,  1, 0, 0, 0, 1);
    vecs[32] = mk(0,  0, 0,  0,  0,  0, 0,  1, 0, 0, 0, 0);

    rst = 1'b0;
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset pend_total", pend_total, 7'd0);
    chk("reset wb_err", 7'(wb_err), 7'd0);
    chk("reset issue_ready", 7'(issue_ready), 7'd1);
    rst = 1'b1;

    // table-driven vectors: outputs observed in the cycle the inputs are applied
    for (int i = 0; i < NV; i++) begin
      logic [10:0] e;
      @(posedge clk);
      #1;
      drive(vecs[i].iv, vecs[i].id, vecs[i].wv, vecs[i].wd, vecs[i].sa, vecs[i].sb, vecs[i].fl);
      exp_q.push_back({vecs[i].r, vecs[i].ha, vecs[i].hb, vecs[i].tot, vecs[i].err});
      #3;
      e = exp_q.pop_front();
      chk($sformatf("v%0d issue_ready", i), 7'(issue_ready), 7'(e[10]));
      chk($sformatf("v%0d hazard_a", i), 7'(hazard_a), 7'(e[9]));
      chk($sformatf("v%0d hazard_b", i), 7'(hazard_b), 7'(e[8]));
      chk($sformatf("v%0d pend_total", i), pend_total, e[7:1]);
      chk($sformatf("v%0d wb_err", i), 7'(wb_err), 7'(e[0]));
    end

    // asynchronous reset mid-operation with a wb_err pending
    @(posedge clk); #1; drive(1, 5'd5, 0, 5'd0, 5'd0, 5'd0, 0);
    @(posedge clk); #1; drive(1, 5'd6, 0, 5'd0, 5'd0, 5'd0, 0);
    @(posedge clk); #1; drive(0, 5'd0, 1, 5'd8, 5'd0, 5'd0, 0);
    @(posedge clk); #1; drive(0, 5'd5, 0, 5'd0, 5'd5, 5'd6, 0);
    #3;
    chk("pre-rst wb_err", 7'(wb_err), 7'd1);
    chk("pre-rst pend_total", pend_total, 7'd2);
    chk("pre-rst hazard_a", 7'(hazard_a), 7'd1);
    #1 rst = 1'b0;
    #1;
    chk("async rst pend_total", pend_total, 7'd0);
    chk("async rst wb_err", 7'(wb_err), 7'd0);
    chk("async rst hazard_a", 7'(hazard_a), 7'd0);
    chk("async rst hazard_b", 7'(hazard_b), 7'd0);
    chk("async rst issue_ready", 7'(issue_ready), 7'd1);
    #2 rst = 1'b1;
    @(posedge clk); #4;
    chk("post-rst wb_err", 7'(wb_err), 7'd0);
    chk("post-rst pend_total", pend_total, 7'd0);
    chk("post-rst hazard_a", 7'(hazard_a), 7'd0);
    @(posedge clk); #4;
    chk("post-rst wb_err 2", 7'(wb_err), 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
